// File: rtl/approx_mult_pipe_if.sv
// Operand/result stream bundle for approx_mult_pipe: an operand beat channel
// and a product result channel, each with a valid/ready handshake.
interface approx_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 approx;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;
  logic                 z_approx;

  // Producer/consumer side of the stream.
  modport master (
    output in_valid, x, y, approx, out_ready,
    input  in_ready, out_valid, z, z_approx
  );

  // Multiplier side of the stream.
  modport slave (
    input  in_valid, x, y, approx, out_ready,
    output in_ready, out_valid, z, z_approx
  );
endinterface

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined unsigned WIDTHxWIDTH multiplier with exact and column-truncated
// approximate modes. Define ERR_STAT_EN to add approximation-error statistics counters.
module approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 8,
  parameter int ERR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_mult_pipe_if.slave  bus
`ifdef ERR_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [ERR_W-1:0]   err_sum,
  output logic [ERR_W-1:0]   op_cnt
`endif
);

  localparam int PW = 2 * WIDTH;

  // Sum of every partial product at column >= TRUNC, plus the OR of column TRUNC-1
  // placed at weight TRUNC-1; lower columns are discarded, so the result never
  // exceeds the exact product.
  function automatic logic [PW-1:0] approx_prod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [PW-1:0] acc;
    logic          or_col;
    acc    = '0;
    or_col = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j >= TRUNC)
          acc = acc + (PW'(a[i] & b[j]) << (i + j));
        else if (i + j == TRUNC - 1)
          or_col = or_col | (a[i] & b[j]);
      end
    end
    return acc + (PW'(or_col) << (TRUNC - 1));
  endfunction

  logic                s1_v;
  logic                s2_v;
  logic                s1_adv;
  logic                s2_adv;
  logic [WIDTH-1:0]    s1_x;
  logic [WIDTH-1:0]    s1_y;
  logic                s1_approx;
  logic [PW-1:0]       exact_next;
  logic [PW-1:0]       z_next;
  logic [PW-1:0]       z_q;
  logic                z_approx_q;

  assign s2_adv = !s2_v || bus.out_ready;
  assign s1_adv = !s1_v || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_v;
  assign bus.z         = z_q;
  assign bus.z_approx  = z_approx_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    exact_next = PW'(s1_x) * PW'(s1_y);
    z_next     = exact_next;
    if (s1_approx)
      z_next = approx_prod(s1_x, s1_y);
  end

  // Valid bits and the visible result are reset; the pipeline advances on s1_adv/s2_adv.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      z_q        <= '0;
      z_approx_q <= 1'b0;
    end else begin
      if (s1_adv)
        s1_v <= bus.in_valid;
      if (s2_adv)
        s2_v <= s1_v;
      if (s2_adv && s1_v) begin
        z_q        <= z_next;
        z_approx_q <= s1_approx;
      end
    end
  end

  // NOTE: operand registers carry no reset; they load only on an accepted beat and are
  // only consumed while s1_v is set, so stale or unknown contents never reach z.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      s1_x      <= bus.x;
      s1_y      <= bus.y;
      s1_approx <= bus.approx;
    end
  end

`ifdef ERR_STAT_EN
  localparam int SUM_W = ((ERR_W > PW) ? ERR_W : PW) + 1;

  logic [PW-1:0]    exact_q;
  logic [SUM_W-1:0] err_ext;
  logic             stat_upd;

  // Exact product travels with the S2 result so the error is known on emission.
  always_ff @(posedge clk) begin
    if (s2_adv && s1_v)
      exact_q <= exact_next;
  end

  assign stat_upd = s2_v && bus.out_ready && z_approx_q;
  assign err_ext  = SUM_W'(err_sum) + SUM_W'(exact_q - z_q);

  // stat_clr takes priority over a coincident update; both counters saturate.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      err_sum <= '0;
      op_cnt  <= '0;
    end else if (stat_upd) begin
      if (err_ext > SUM_W'({ERR_W{1'b1}}))
        err_sum <= '1;
      else
        err_sum <= err_ext[ERR_W-1:0];
      if (op_cnt != '1)
        op_cnt <= op_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed literal cases, back-to-back
// throughput, randomized backpressure against a row-based reference model, mid-stream reset.
module tb_approx_mult_pipe;

  localparam int W  = 8;
  localparam int T  = 8;
  localparam int EW = 32;

  typedef struct {
    logic [2*W-1:0] z;
    logic           a;
    logic [2*W-1:0] ex;
  } exp_t;

  logic clk;
  logic rst_n;
  approx_mult_pipe_if #(.WIDTH(W)) bus ();

`ifdef ERR_STAT_EN
  logic          stat_clr;
  logic [EW-1:0] err_sum;
  logic [EW-1:0] op_cnt;
  longint        m_err;
  longint        m_cnt;
`endif

  approx_mult_pipe #(.WIDTH(W), .TRUNC(T), .ERR_W(EW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef ERR_STAT_EN
    ,
    .stat_clr (stat_clr),
    .err_sum  (err_sum),
    .op_cnt   (op_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: add each operand row y<<i masked to columns >= T, then set bit T-1
  // if any x[i]&y[T-1-i] is one.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ap);
    logic [31:0] acc;
    logic [31:0] hi_mask;
    logic        orb;
    int          k;
    if (!ap) return 16'(a) * 16'(b);
    acc     = 32'd0;
    orb     = 1'b0;
    hi_mask = ~((32'd1 << T) - 32'd1);
    for (int i = 0; i < W; i++) begin
      if (a[i]) begin
        acc = acc + ((32'(b) << i) & hi_mask);
        k = T - 1 - i;
        if (k >= 0 && k < W && b[k]) orb = 1'b1;
      end
    end
    acc = acc + (32'(orb) << (T - 1));
    return acc[2*W-1:0];
  endfunction

  // Compare process: the queue mirrors the beats inside the DUT at each falling edge.
  logic           held_v = 1'b0;
  logic [2*W-1:0] held_z;
  logic           held_a;

  always @(negedge clk) begin
    if (held_v) begin
      check("stall_valid_held", bus.out_valid, 1);
      check("stall_z_held", bus.z, held_z);
      check("stall_mode_held", bus.z_approx, held_a);
    end
    held_v = 1'b0;
    if (!rst_n) begin
      q.delete();
`ifdef ERR_STAT_EN
      m_err = 0;
      m_cnt = 0;
`endif
    end else begin
      check("in_ready", bus.in_ready, !(q.size() == 2 && !bus.out_ready));
`ifdef ERR_STAT_EN
      check("err_sum", err_sum, m_err);
      check("op_cnt", op_cnt, m_cnt);
`endif
      if (bus.out_valid) begin
        check("out_valid_has_beat", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("z", bus.z, q[0].z);
          check("z_approx", bus.z_approx, q[0].a);
          if (bus.out_ready) begin
`ifdef ERR_STAT_EN
            if (!stat_clr && q[0].a) begin
              m_err = m_err + longint'(q[0].ex - q[0].z);
              if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
              if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
`endif
            void'(q.pop_front());
            n_pop++;
          end else begin
            held_v = 1'b1;
            held_z = bus.z;
            held_a = bus.z_approx;
          end
        end
      end
`ifdef ERR_STAT_EN
      if (stat_clr) begin
        m_err = 0;
        m_cnt = 0;
      end
`endif
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{z: model(bus.x, bus.y, bus.approx), a: bus.approx,
                      ex: model(bus.x, bus.y, 1'b0)});
        n_push++;
      end
    end
  end

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                        input logic [2*W-1:0] exp_z, input string name);
    bus.in_valid  = 1'b1;
    bus.x         = a;
    bus.y         = b;
    bus.approx    = ap;
    bus.out_ready = 1'b1;
    check({name, "_accept"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check({name, "_valid"}, bus.out_valid, 1);
    check({name, "_z"}, bus.z, exp_z);
    check({name, "_mode"}, bus.z_approx, ap);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ov[20];
    int   first, last, ones, cyc, start;

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.approx    = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
`ifdef ERR_STAT_EN
    stat_clr      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_z", bus.z, 0);
    check("reset_in_ready", bus.in_ready, 1);

    // Pin the reference model to hand-computed products.
    check("model_3xC0_approx", model(8'h03, 8'hC0, 1'b1), 384);
    check("model_3xC0_exact", model(8'h03, 8'hC0, 1'b0), 576);
    check("model_0Fx0F_approx", model(8'h0F, 8'h0F, 1'b1), 0);
    check("model_80x80_approx", model(8'h80, 8'h80, 1'b1), 16384);
    check("model_01x80_approx", model(8'h01, 8'h80, 1'b1), 128);

    single(8'h03, 8'hC0, 1'b1, 16'd384, "d_3xC0_ap");
`ifdef ERR_STAT_EN
    @(posedge clk); #1;
    check("d_err_sum_192", err_sum, 192);
    check("d_op_cnt_1", op_cnt, 1);
`endif
    single(8'h03, 8'hC0, 1'b0, 16'd576, "d_3xC0_ex");
    single(8'h0F, 8'h0F, 1'b1, 16'd0, "d_0Fx0F_ap");
    single(8'h80, 8'h80, 1'b1, 16'd16384, "d_80x80_ap");
    single(8'h01, 8'h80, 1'b1, 16'd128, "d_01x80_ap");
    single(8'hFF, 8'hFF, 1'b0, 16'd65025, "d_FFxFF_ex");

    // Back-to-back: 16 beats, out_ready high throughout.
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int t = 0; t < 20; t++) begin
      bus.in_valid = (t < 16);
      bus.x        = W'($urandom);
      bus.y        = W'($urandom);
      bus.approx   = 1'($urandom);
      @(posedge clk); #1;
      ov[t] = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    first = -1; last = -1; ones = 0;
    for (int t = 0; t < 20; t++) begin
      if (ov[t]) begin
        if (first < 0) first = t;
        last = t;
        ones++;
      end
    end
    check("b2b_latency", first, 1);
    check("b2b_count", ones, 16);
    check("b2b_contiguous", last - first + 1, 16);

    // Randomized traffic with 50% out_ready until 10k beats are accepted.
    start = n_push;
    cyc   = 0;
    while ((n_push - start) < 10000 && cyc < 60000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.x         = W'($urandom);
      bus.y         = W'($urandom);
      bus.approx    = 1'($urandom);
      bus.out_ready = 1'($urandom);
`ifdef ERR_STAT_EN
      stat_clr      = ($urandom_range(0, 199) == 0);
`endif
      @(posedge clk); #1;
      cyc++;
    end
    check("random_beats_accepted", (n_push - start) >= 10000, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ERR_STAT_EN
    stat_clr      = 1'b0;
`endif
    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    check("no_loss_or_dup", n_pop, n_push);

    // Mid-stream reset with two beats in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.approx    = 1'b1;
    bus.x         = 8'h03;
    bus.y         = 8'hC0;
    repeat (2) @(posedge clk);
    #1;
    check("inflight_stalled_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    ones = 0;
    for (int t = 0; t < 6; t++) begin
      ones += int'(bus.out_valid);
      @(posedge clk); #1;
    end
    check("post_reset_no_valid", ones, 0);
`ifdef ERR_STAT_EN
    check("post_reset_err_sum", err_sum, 0);
    check("post_reset_op_cnt", op_cnt, 0);
    single(8'h03, 8'hC0, 1'b1, 16'd384, "s_first");
    @(posedge clk); #1;
    check("s_err_before_clr", err_sum, 192);
    single(8'h03, 8'hC0, 1'b1, 16'd384, "s_second");
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("clr_wins_err_sum", err_sum, 0);
    check("clr_wins_op_cnt", op_cnt, 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
